// File: rtl/ga_crossover_sched.sv
// Generation scheduler between ga_selection and ga_crossover: passes exactly cnfg_p parent pairs per
// generation, sequences up to cnfg_g generations, stops early on convergence. Define GA_SCHED_PERF_EN for perf_stall_cnt.
module ga_crossover_sched #(
  parameter int P_MAX       = 1024,
  parameter int G_MAX       = 1024,
  parameter int P_MAX_W     = $clog2(P_MAX+1),
  parameter int G_MAX_W     = $clog2(G_MAX+1),
  parameter int FIT_SCORE_W = 18
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sw_rst,
  input  logic [P_MAX_W-1:0]     cnfg_p,
  input  logic [G_MAX_W-1:0]     cnfg_g,
  input  logic [FIT_SCORE_W-1:0] cnfg_max_fit_score,
  input  logic                   start,
  input  logic                   gen_best_valid,
  input  logic [FIT_SCORE_W-1:0] gen_best_score,
  input  logic                   sel_parents_valid,
  output logic                   sel_parents_ack,
  output logic                   xo_parents_valid,
  input  logic                   xo_parents_ack,
  input  logic                   child_valid,
  input  logic                   child_ack,
  output logic                   gen_start,
  output logic [G_MAX_W-1:0]     gen_idx,
  output logic                   busy,
  output logic                   done,
`ifdef GA_SCHED_PERF_EN
  output logic [15:0]            perf_stall_cnt,
`endif
  output logic                   converged
);

  typedef enum logic [2:0] {IDLE, GSTART, RUN, DRAIN, CHECK, DONE} state_t;

  state_t                 state;
  logic [P_MAX_W-1:0]     issued_cnt, accepted_cnt, cfg_p;
  logic [G_MAX_W-1:0]     cfg_g;
  logic [FIT_SCORE_W-1:0] cfg_thr, best_reg;
  logic                   best_valid_seen, acc_err;

  logic                   gate_open, in_flow, xo_hs, ch_hs, ch_ok, best_cap;
  logic [P_MAX_W-1:0]     iss_nx, acc_nx;

  assign in_flow          = (state == RUN) || (state == DRAIN);
  assign gate_open        = (state == RUN) && (issued_cnt < cfg_p);
  assign xo_parents_valid = sel_parents_valid & gate_open;
  assign sel_parents_ack  = xo_parents_ack & gate_open;
  assign xo_hs            = xo_parents_valid & xo_parents_ack;
  assign ch_hs            = child_valid & child_ack & in_flow;
  // A child accept may land in the same cycle as its own pair's issue, so bound against iss_nx.
  assign ch_ok            = ch_hs && (accepted_cnt < iss_nx);
  assign iss_nx           = issued_cnt + P_MAX_W'(xo_hs);
  assign acc_nx           = accepted_cnt + P_MAX_W'(ch_ok);
  assign best_cap         = gen_best_valid && (state == GSTART || in_flow);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;       issued_cnt <= '0;  accepted_cnt <= '0;  gen_idx <= '0;
      best_reg <= '0;      best_valid_seen <= 1'b0;  acc_err <= 1'b0;
      cfg_p <= '0;         cfg_g <= '0;       cfg_thr <= '0;
      gen_start <= 1'b0;   busy <= 1'b0;      done <= 1'b0;        converged <= 1'b0;
    end else if (sw_rst) begin
      state <= IDLE;       issued_cnt <= '0;  accepted_cnt <= '0;  gen_idx <= '0;
      best_reg <= '0;      best_valid_seen <= 1'b0;  acc_err <= 1'b0;
      cfg_p <= '0;         cfg_g <= '0;       cfg_thr <= '0;
      gen_start <= 1'b0;   busy <= 1'b0;      done <= 1'b0;        converged <= 1'b0;
    end else begin
      gen_start <= 1'b0;
      acc_err   <= acc_err | (ch_hs & ~ch_ok);
      if (best_cap) begin
        best_reg        <= gen_best_score;
        best_valid_seen <= 1'b1;
      end
      case (state)
        IDLE, DONE: if (start) begin
          cfg_p <= cnfg_p;  cfg_g <= cnfg_g;  cfg_thr <= cnfg_max_fit_score;
          gen_idx <= '0;    issued_cnt <= '0; accepted_cnt <= '0;  best_valid_seen <= 1'b0;
          done <= 1'b0;     converged <= 1'b0;
          busy <= 1'b1;     gen_start <= 1'b1;
          state <= GSTART;
        end
        GSTART: state <= RUN;
        RUN: begin
          issued_cnt   <= iss_nx;
          accepted_cnt <= acc_nx;
          if (iss_nx == cfg_p) state <= (acc_nx == cfg_p) ? CHECK : DRAIN;
        end
        DRAIN: begin
          accepted_cnt <= acc_nx;
          if (acc_nx == cfg_p) state <= CHECK;
        end
        CHECK: begin
          if (best_valid_seen && (best_reg >= cfg_thr)) begin
            state <= DONE;  done <= 1'b1;  converged <= 1'b1;  busy <= 1'b0;
          end else if (gen_idx == cfg_g - G_MAX_W'(1)) begin
            state <= DONE;  done <= 1'b1;  converged <= 1'b0;  busy <= 1'b0;
          end else begin
            gen_idx <= gen_idx + G_MAX_W'(1);
            issued_cnt <= '0;  accepted_cnt <= '0;  best_valid_seen <= 1'b0;
            gen_start <= 1'b1;
            state <= GSTART;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Children accepted beyond what was issued means the crossover side broke protocol.
  acc_never_exceeds_issue: assert property (@(posedge clk) disable iff (!rstn) !acc_err);

`ifdef GA_SCHED_PERF_EN
  logic stall;
  assign stall = in_flow && ((sel_parents_valid && !xo_parents_ack) || (child_valid && !child_ack));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      perf_stall_cnt <= '0;
    else if (sw_rst)                perf_stall_cnt <= '0;
    else if (state == GSTART)       perf_stall_cnt <= '0;
    else if (stall && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/ga_crossover_sched.md
Name: ga_crossover_sched

Overview:
Generation scheduler for the GA crossover datapath. It sits between ga_selection and ga_crossover and gates the parent-pair handshake so that exactly cnfg_p children are produced per generation. It counts accepted children and sequences generations up to cnfg_g. It terminates early when the generation's best fitness score reaches cnfg_max_fit_score.

Parameters:
P_MAX  1024  max individuals per generation
G_MAX  1024  max generations
P_MAX_W  $clog2(P_MAX+1)  population count width
G_MAX_W  $clog2(G_MAX+1)  generation count width
FIT_SCORE_W  18  unsigned fixed-point fitness width

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
sw_rst  in  1  sync soft reset; same effect as rstn, applied on the clock edge
cnfg_p  in  P_MAX_W  children per generation; legal range 2..P_MAX
cnfg_g  in  G_MAX_W  max generations; legal range 1..G_MAX
cnfg_max_fit_score  in  FIT_SCORE_W  convergence threshold
start  in  1  one-cycle pulse that starts a run
gen_best_valid  in  1  pulse from selection qualifying gen_best_score
gen_best_score  in  FIT_SCORE_W  best score of the current generation
sel_parents_valid  in  1  selection has a parent pair
sel_parents_ack  out  1  ack to selection (gated)
xo_parents_valid  out  1  valid to crossover (gated)
xo_parents_ack  in  1  ack from crossover
child_valid  in  1  crossover child valid
child_ack  in  1  downstream child accept
gen_start  out  1  one-cycle pulse at the start of each generation
gen_idx  out  G_MAX_W  current generation index, starting at 0
busy  out  1  run in progress
done  out  1  level; high from the end of a run until the next start
converged  out  1  qualifies done: 1 = threshold reached, 0 = cnfg_g exhausted

Behaviour:
- Reset (rstn low or sw_rst high):
  - state IDLE.
  - All outputs 0; all counters 0.
  - best_reg is 0.
  - The reset is allowed mid-run: any in-flight handshake is abandoned, with no pending-state memory.
- States: IDLE, GSTART, RUN, DRAIN, CHECK, DONE.
- IDLE/DONE:
  - start -> GSTART.
  - cnfg_* are sampled into shadow registers on start and are stable for the whole run.
  - In DONE, done and converged hold their values until start; start clears done the next cycle.
- GSTART (1 cycle):
  - gen_start = 1; issued_cnt = 0; accepted_cnt = 0; best_valid_seen = 0.
  - Next state RUN.
- RUN:
  - xo_parents_valid = sel_parents_valid and sel_parents_ack = xo_parents_ack, combinational passthrough, only while issued_cnt < cnfg_p.
  - issued_cnt increments on xo_parents_valid & xo_parents_ack.
  - When the handshake that makes issued_cnt == cnfg_p completes, both gated signals are forced 0 from the next cycle. No extra pair leaks through.
  - Transition to DRAIN when issued_cnt == cnfg_p.
- accepted_cnt:
  - Increments on child_valid & child_ack in RUN or DRAIN.
  - It is never allowed to exceed issued_cnt; a violation sets an internal sticky error, which is visible in simulation only.
- DRAIN: gating held closed; -> CHECK when accepted_cnt == cnfg_p.
  - A child handshake in the same cycle as the last issue is counted normally.
- gen_best_valid:
  - Captured into best_reg in any of GSTART, RUN or DRAIN.
  - The last pulse wins; best_valid_seen is set on capture.
- CHECK (1 cycle), checks in priority order:
  - If best_valid_seen && best_reg >= cnfg_max_fit_score (unsigned): -> DONE, converged = 1.
  - Else, if gen_idx == cnfg_g-1: -> DONE, converged = 0.
  - Else: gen_idx increments, -> GSTART.
- busy = 1 in GSTART, RUN, DRAIN and CHECK.
- Latency: start -> gen_start is 1 cycle; last child accept -> next gen_start is 2 cycles (CHECK, then GSTART).
- start while busy is ignored.

Optional Feature:
GA_SCHED_PERF_EN
- Defined: adds output perf_stall_cnt (16 bit, saturating).
  - It counts RUN/DRAIN cycles with sel_parents_valid & ~xo_parents_ack, or with child_valid & ~child_ack.
  - Cleared at GSTART; the value for the finished generation is held through CHECK.
- Undefined: the port and its logic are absent.

Test Plan:
1. cnfg_p=4, cnfg_g=3, threshold=max, crossover acks every cycle:
   - exactly 4 acks reach selection per generation.
   - gen_start pulses 3 times; gen_idx runs 0,1,2.
   - done=1 with converged=0.
2. cnfg_p=2; selection holds valid after 2 issues:
   - xo_parents_valid stays 0 until the next GSTART.
   - no third handshake occurs.
3. cnfg_p=4, cnfg_g=10, threshold={8'd32,10'd0}:
   - gen_best_score=200 in gen 0 -> gen 1 starts.
   - gen_best_score={3'b111,15'b0} in gen 1 -> done, converged=1, gen_idx=1.
4. Child backpressure (child_ack low for 5 cycles after the last issue):
   - DRAIN holds.
   - gen_start comes 2 cycles after the 4th child accept.
5. rstn asserted in RUN with issued_cnt=1:
   - all outputs 0 immediately.
   - after release, start restarts at gen_idx=0 with counts cleared.
6. start pulsed while busy: no effect on gen_idx or counters; sw_rst in DRAIN returns to IDLE on the next edge.
